// File: rtl/adc_pkg.sv
// Shared constants and FSM state encoding for the PSD-chip ADC readout path.
package adc_pkg;
  localparam int ADC_WORD_BITS = 16;
  localparam int NUM_PSD_CHIPS = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] CONV  = 3'd1;
  localparam logic [STATE_W-1:0] SETUP = 3'd2;
  localparam logic [STATE_W-1:0] SHIFT = 3'd3;
  localparam logic [STATE_W-1:0] HOLD  = 3'd4;
  localparam logic [STATE_W-1:0] FIN   = 3'd5;
endpackage

// File: rtl/adc_sclk_divider.sv
// Half-period tick generator: tick fires on every CLK_DIV-th enabled cycle.
module adc_sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic adc_reg_reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge adc_reg_reset) begin
    if (adc_reg_reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_reg == LAST);
endmodule

// File: rtl/adc_readout_ctrl.sv
// ADC serial-link master: convert strobe, chip select and gated per-chip sclk.
// Outputs are flops fed from the current state, so they trail the state by one cycle.
module adc_readout_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int NUM_BITS    = ADC_WORD_BITS,
  parameter int CONV_CYCLES = 50
) (
  input  logic                     clk,
  input  logic                     adc_reg_reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_PSD_CHIPS-1:0] chip_en,
  output logic                     adc_cnv,
  output logic [NUM_PSD_CHIPS-1:0] adc_cs_n,
  output logic [NUM_PSD_CHIPS-1:0] adc_sclk,
  output logic                     busy,
  output logic                     done
);
  localparam int BW  = $clog2(NUM_BITS + 1);
  localparam int CCW = $clog2(CONV_CYCLES + 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(NUM_BITS - 1);
  localparam logic [CCW-1:0] CONV_LAST = CCW'(CONV_CYCLES - 1);

  logic [STATE_W-1:0]       state_reg, state_next;
  logic [NUM_PSD_CHIPS-1:0] en_reg, en_next;
  logic [CCW-1:0]           conv_cnt_reg, conv_cnt_next;
  logic [BW-1:0]            bit_cnt_reg, bit_cnt_next;
  logic                     phase_reg, phase_next;

  logic                     adc_cnv_reg, adc_cnv_next;
  logic [NUM_PSD_CHIPS-1:0] adc_cs_n_reg, adc_cs_n_next;
  logic [NUM_PSD_CHIPS-1:0] adc_sclk_reg, adc_sclk_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;

  logic timed;
  logic tick;
  logic cancel;

  assign timed  = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD);
  assign cancel = abort && (state_reg != IDLE);

  adc_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk           (clk),
    .adc_reg_reset (adc_reg_reset),
    .en            (timed),
    .clr           (!timed),
    .tick          (tick)
  );

  always_ff @(posedge clk or posedge adc_reg_reset) begin
    if (adc_reg_reset) begin
      state_reg    <= IDLE;
      en_reg       <= '0;
      conv_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      phase_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      en_reg       <= en_next;
      conv_cnt_reg <= conv_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      phase_reg    <= phase_next;
    end
  end

  // phase_reg=1 marks the high half of an sclk period; a falling half ends a bit.
  always_comb begin
    state_next    = state_reg;
    en_next       = en_reg;
    conv_cnt_next = conv_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    phase_next    = phase_reg;
    case (state_reg)
      IDLE: if (start) begin
        state_next    = CONV;
        en_next       = chip_en;
        conv_cnt_next = '0;
      end
      CONV: begin
        if (conv_cnt_reg == CONV_LAST) state_next = SETUP;
        else                           conv_cnt_next = conv_cnt_reg + 1'b1;
      end
      SETUP: if (tick) begin
        state_next   = SHIFT;
        phase_next   = 1'b1;
        bit_cnt_next = '0;
      end
      SHIFT: if (tick) begin
        if (phase_reg) begin
          phase_next = 1'b0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_LAST) state_next = HOLD;
          else                         phase_next = 1'b1;
        end
      end
      HOLD:    if (tick) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cancel) state_next = IDLE;
  end

  always_comb begin
    adc_cnv_next  = (state_reg == CONV);
    adc_cs_n_next = timed ? ~en_reg : '1;
    adc_sclk_next = ((state_reg == SHIFT) && phase_reg) ? en_reg : '0;
    busy_next     = (state_reg == CONV) || timed;
    done_next     = (state_reg == FIN);
    if (cancel) begin
      adc_cnv_next  = 1'b0;
      adc_cs_n_next = '1;
      adc_sclk_next = '0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge adc_reg_reset) begin
    if (adc_reg_reset) begin
      adc_cnv_reg  <= 1'b0;
      adc_cs_n_reg <= '1;
      adc_sclk_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      adc_cnv_reg  <= adc_cnv_next;
      adc_cs_n_reg <= adc_cs_n_next;
      adc_sclk_reg <= adc_sclk_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign adc_cnv  = adc_cnv_reg;
  assign adc_cs_n = adc_cs_n_reg;
  assign adc_sclk = adc_sclk_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Scoreboard bench: ADC/capture-register model per chip, expected reads queued at start.
module tb_adc_readout_ctrl;
  logic       clk = 1'b0;
  logic       adc_reg_reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic [1:0] chip_en = 2'b00;
  logic       adc_cnv, busy, done;
  logic [1:0] adc_cs_n, adc_sclk;

  logic       f_start = 1'b0, f_abort = 1'b0;
  logic [1:0] f_chip_en = 2'b11;
  logic       f_cnv, f_busy, f_done;
  logic [1:0] f_cs_n, f_sclk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_seen = 0;
  int f_done_seen = 0;
  int ffcnt = 0;
  int t2_viol = 0;
  bit t2_win = 1'b0;

  logic [15:0] adc_word [8];

  typedef struct {
    int          exp_cyc;
    bit          chk_data;
    logic [15:0] exp_c0;
    logic [15:0] exp_c7;
    int          exp_fe0;
    int          exp_fe1;
  } exp_t;
  exp_t sb_q[$];
  exp_t sbf_q[$];

  adc_readout_ctrl dut (
    .clk(clk), .adc_reg_reset(adc_reg_reset), .start(start), .abort(abort),
    .chip_en(chip_en), .adc_cnv(adc_cnv), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .busy(busy), .done(done)
  );

  adc_readout_ctrl #(.CLK_DIV(1), .NUM_BITS(16), .CONV_CYCLES(1)) dut_fast (
    .clk(clk), .adc_reg_reset(adc_reg_reset), .start(f_start), .abort(f_abort),
    .chip_en(f_chip_en), .adc_cnv(f_cnv), .adc_cs_n(f_cs_n), .adc_sclk(f_sclk),
    .busy(f_busy), .done(f_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge f_sclk[0]) ffcnt <= ffcnt + 1;
  always @(negedge clk) if (t2_win && (adc_sclk[1] || !adc_cs_n[1])) t2_viol <= t2_viol + 1;

  // ADC SDO plus capture shift registers: four lanes per chip, MSB first.
  for (genvar gi = 0; gi < 2; gi++) begin : chip
    logic [15:0] lane_cap [4];
    int bidx = 0;
    int fcnt = 0;
    always @(negedge adc_sclk[gi] or posedge adc_cs_n[gi] or posedge adc_reg_reset) begin
      if (adc_reg_reset) begin
        for (int l = 0; l < 4; l++) lane_cap[l] <= '0;
        bidx <= 0;
      end else if (adc_cs_n[gi]) begin
        bidx <= 0;
      end else begin
        for (int l = 0; l < 4; l++)
          lane_cap[l] <= {lane_cap[l][14:0], (bidx < 16) ? adc_word[gi*4+l][15-bidx] : 1'b0};
        bidx <= bidx + 1;
        fcnt <= fcnt + 1;
      end
    end
  end

  wire [15:0] cap_sel0 = chip[0].lane_cap[0];
  wire [15:0] cap_sel7 = chip[1].lane_cap[3];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!adc_reg_reset && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", cyc, e.exp_cyc);
        chk("busy_at_done", busy, 0);
        chk("fe_chip0", chip[0].fcnt, e.exp_fe0);
        chk("fe_chip1", chip[1].fcnt, e.exp_fe1);
        if (e.chk_data) begin
          chk("mux_sel0", cap_sel0, e.exp_c0);
          chk("mux_sel7", cap_sel7, e.exp_c7);
        end
        $display("read done at cycle %0d: sel0=%h sel7=%h", cyc, cap_sel0, cap_sel7);
      end
    end
  end

  always @(negedge clk) begin : mon_fast
    exp_t e;
    if (!adc_reg_reset && f_done) begin
      f_done_seen++;
      if (sbf_q.size() == 0) begin
        chk("fast_unexpected_done", 1, 0);
      end else begin
        e = sbf_q.pop_front();
        chk("fast_done_cycle", cyc, e.exp_cyc);
        chk("fast_fe_chip0", ffcnt, e.exp_fe0);
        $display("fast read done at cycle %0d, sclk falls=%0d", cyc, ffcnt);
      end
    end
  end

  task automatic start_read(input logic [1:0] en, output int n);
    @(negedge clk);
    start = 1'b1;
    chip_en = en;
    @(posedge clk);
    #1;
    n = cyc;
    start = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic [15:0] c0, input logic [15:0] c7,
                          input int fe0, input int fe1);
    exp_t e;
    e.exp_cyc = c; e.chk_data = 1'b1; e.exp_c0 = c0; e.exp_c7 = c7;
    e.exp_fe0 = fe0; e.exp_fe1 = fe1;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_seen < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", done_seen >= target, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sclk_high(input int fe_target, input int budget);
    int k = 0;
    while (!(chip[0].fcnt >= fe_target && adc_sclk[0]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("reached_shift", k < budget, 1);
  endtask

  initial begin
    int n, b0, b1, ds;
    exp_t ef;
    adc_word[0] = 16'hA5C3; adc_word[1] = 16'h1234; adc_word[2] = 16'hFFFF; adc_word[3] = 16'h0F0F;
    adc_word[4] = 16'h8001; adc_word[5] = 16'h5555; adc_word[6] = 16'hAAAA; adc_word[7] = 16'h3C5A;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cnv", adc_cnv, 0);
    chk("rst_cs_n", adc_cs_n, 2'b11);
    chk("rst_sclk", adc_sclk, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    adc_reg_reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: both chips, full read
    b0 = chip[0].fcnt; b1 = chip[1].fcnt;
    start_read(2'b11, n);
    push_exp(n + 187, 16'hA5C3, 16'h3C5A, b0 + 16, b1 + 16);
    chk("busy_before_n1", busy, 0);
    @(posedge clk); #1;
    chk("busy_at_n1", busy, 1);
    chk("cnv_at_n1", adc_cnv, 1);
    wait_done(1, 400);

    // Reset clears the capture registers
    @(negedge clk); adc_reg_reset = 1'b1;
    @(negedge clk);
    chk("rst_cap0", cap_sel0, 0);
    chk("rst_cap7", cap_sel7, 0);
    adc_reg_reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2: chip0 only
    b0 = chip[0].fcnt; b1 = chip[1].fcnt;
    t2_win = 1'b1;
    start_read(2'b01, n);
    push_exp(n + 187, 16'hA5C3, 16'h0000, b0 + 16, b1);
    wait_done(2, 400);
    t2_win = 1'b0;
    chk("chip1_idle_violations", t2_viol, 0);

    // 3: start while busy is ignored
    b0 = chip[0].fcnt; b1 = chip[1].fcnt; ds = done_seen;
    start_read(2'b11, n);
    push_exp(n + 187, 16'hA5C3, 16'h3C5A, b0 + 16, b1 + 16);
    @(negedge clk); start = 1'b1; @(posedge clk); #1; start = 1'b0;
    while (cyc < n + 99) @(negedge clk);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_done(ds + 1, 400);
    repeat (250) @(negedge clk);
    chk("single_done", done_seen, ds + 1);

    // 4: abort in SHIFT after 7 falling edges
    b0 = chip[0].fcnt; ds = done_seen;
    start_read(2'b11, n);
    wait_sclk_high(b0 + 7, 300);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_sclk", adc_sclk, 2'b00);
    chk("abort_cs_n", adc_cs_n, 2'b11);
    chk("abort_busy", busy, 0);
    chk("abort_cnv", adc_cnv, 0);
    repeat (250) @(negedge clk);
    chk("abort_no_done", done_seen, ds);
    b0 = chip[0].fcnt; b1 = chip[1].fcnt;
    start_read(2'b11, n);
    push_exp(n + 187, 16'hA5C3, 16'h3C5A, b0 + 16, b1 + 16);
    wait_done(ds + 1, 400);

    // 5: asynchronous reset mid-SHIFT
    b0 = chip[0].fcnt; ds = done_seen;
    start_read(2'b11, n);
    wait_sclk_high(b0 + 3, 300);
    #2 adc_reg_reset = 1'b1;
    #1;
    chk("arst_sclk", adc_sclk, 2'b00);
    chk("arst_cs_n", adc_cs_n, 2'b11);
    chk("arst_busy", busy, 0);
    chk("arst_cnv", adc_cnv, 0);
    chk("arst_cap0", cap_sel0, 0);
    chk("arst_cap7", cap_sel7, 0);
    @(negedge clk); adc_reg_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_idle_busy", busy, 0);
    chk("arst_no_done", done_seen, ds);
    b0 = chip[0].fcnt; b1 = chip[1].fcnt;
    start_read(2'b11, n);
    push_exp(n + 187, 16'hA5C3, 16'h3C5A, b0 + 16, b1 + 16);
    wait_done(ds + 1, 400);

    // 6: CLK_DIV=1, CONV_CYCLES=1
    b0 = ffcnt;
    @(negedge clk); f_start = 1'b1;
    @(posedge clk); #1; n = cyc; f_start = 1'b0;
    ef.exp_cyc = n + 36; ef.chk_data = 1'b0; ef.exp_c0 = '0; ef.exp_c7 = '0;
    ef.exp_fe0 = b0 + 16; ef.exp_fe1 = 0;
    sbf_q.push_back(ef);
    @(posedge clk); #1;
    chk("fast_busy_n1", f_busy, 1);
    begin
      int k = 0;
      while (f_done_seen < 1 && k < 100) begin @(negedge clk); k++; end
      chk("fast_done_within_budget", f_done_seen, 1);
    end
    repeat (5) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    chk("sbf_empty", sbf_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
